// File: rtl/mips_pkg.sv
// Shared MIPS32 pipeline definitions: ALU control codes,
// ALUOp encodings, R-type funct values and register constants.
package mips_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12,
        ALU_BAD = 4'd15
    } aluctl_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_e;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/alu_control.sv
// Combinational ALUOp/funct to ALU control decoder, shared with
// the single-cycle datapath.
module alu_control
    import mips_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [3:0] o_aluctl
);

    aluctl_e w_fn;
    aluctl_e w_ctl;

    always_comb begin
        w_fn = ALU_BAD;
        unique case (i_funct)
            FN_ADD:  w_fn = ALU_ADD;
            FN_SUB:  w_fn = ALU_SUB;
            FN_AND:  w_fn = ALU_AND;
            FN_OR:   w_fn = ALU_OR;
            FN_NOR:  w_fn = ALU_NOR;
            FN_SLT:  w_fn = ALU_SLT;
            default: w_fn = ALU_BAD;
        endcase
    end

    always_comb begin
        w_ctl = ALU_ADD;
        unique case (i_aluop)
            ALUOP_ADD:   w_ctl = ALU_ADD;
            ALUOP_SUB:   w_ctl = ALU_SUB;
            ALUOP_RTYPE: w_ctl = w_fn;
            ALUOP_OR:    w_ctl = ALU_OR;
            default:     w_ctl = ALU_ADD;
        endcase
    end

    assign o_aluctl = w_ctl;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode, EX/MEM and
// MEM/WB operand forwarding, and load-use hazard detection.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [1:0]    id_aluop,
    input  logic [5:0]    id_funct,
    input  logic          id_alusrc,
    input  logic          id_regdst,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_memtoreg,
    input  logic          stall,
    input  logic          flush,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic          ex_valid,
    output logic [3:0]    ALUctl,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dest,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_memtoreg,
    output logic          load_use_hazard
);

    localparam logic [RW-1:0] R0 = RW'(REG_ZERO);

    logic          r_valid;
    logic [3:0]    r_aluctl;
    logic [RW-1:0] r_dest;
    logic [RW-1:0] r_rs;
    logic [RW-1:0] r_rt;
    logic [DW-1:0] r_rs_data;
    logic [DW-1:0] r_rt_data;
    logic [DW-1:0] r_imm;
    logic          r_alusrc;
    logic          r_regwrite;
    logic          r_memread;
    logic          r_memwrite;
    logic          r_memtoreg;

    logic [3:0]    w_aluctl;
    logic          w_bubble;
    logic [DW-1:0] w_fwd_rs;
    logic [DW-1:0] w_fwd_rt;

    alu_control u_alu_control (
        .i_aluop  (id_aluop),
        .i_funct  (id_funct),
        .o_aluctl (w_aluctl)
    );

    // An empty ID slot is loaded exactly like a flush bubble.
    assign w_bubble = flush | (~stall & ~id_valid);

    always_ff @(posedge clk) begin
        if (reset || w_bubble) begin
            r_valid    <= 1'b0;
            r_aluctl   <= '0;
            r_dest     <= '0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rs_data  <= '0;
            r_rt_data  <= '0;
            r_imm      <= '0;
            r_alusrc   <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
        end else if (!stall) begin
            r_valid    <= 1'b1;
            r_aluctl   <= w_aluctl;
            r_dest     <= id_regdst ? id_rd : id_rt;
            r_rs       <= id_rs;
            r_rt       <= id_rt;
            r_rs_data  <= id_rs_data;
            r_rt_data  <= id_rt_data;
            r_imm      <= id_imm;
            r_alusrc   <= id_alusrc;
            r_regwrite <= id_regwrite;
            r_memread  <= id_memread;
            r_memwrite <= id_memwrite;
            r_memtoreg <= id_memtoreg;
        end
    end

    always_comb begin
        w_fwd_rs = r_rs_data;
        if (exmem_regwrite && exmem_rd != R0 && exmem_rd == r_rs)
            w_fwd_rs = exmem_result;
        else if (memwb_regwrite && memwb_rd != R0 && memwb_rd == r_rs)
            w_fwd_rs = memwb_result;
    end

    always_comb begin
        w_fwd_rt = r_rt_data;
        if (exmem_regwrite && exmem_rd != R0 && exmem_rd == r_rt)
            w_fwd_rt = exmem_result;
        else if (memwb_regwrite && memwb_rd != R0 && memwb_rd == r_rt)
            w_fwd_rt = memwb_result;
    end

    assign alu_a         = w_fwd_rs;
    assign ex_store_data = w_fwd_rt;
    assign alu_b         = r_alusrc ? r_imm : w_fwd_rt;

    assign load_use_hazard = r_valid & r_memread & (r_rt != R0)
                           & ((r_rt == id_rs) | (r_rt == id_rt));

    assign ex_valid    = r_valid;
    assign ALUctl      = r_aluctl;
    assign ex_dest     = r_dest;
    assign ex_regwrite = r_regwrite;
    assign ex_memread  = r_memread;
    assign ex_memwrite = r_memwrite;
    assign ex_memtoreg = r_memtoreg;

endmodule
